// File: rtl/clk_stall_ctrl_pkg.sv
// clk_stall_ctrl_pkg: FSM encoding, default parameters and index-width helper for clk_stall_ctrl
package clk_stall_ctrl_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, STALL = 2'd1, RELEASE = 2'd2} state_t;
  localparam int DEF_N_SRC = 2;
  localparam int DEF_DIV_W = 4;
  localparam int DEF_TO_W = 8;
  localparam int MAX_N_SRC = 8;
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/clk_stall_ctrl_arb.sv
// rr_arbiter: combinational round-robin pick of the first set request at or above ptr, modulo N_SRC
module rr_arbiter
  import clk_stall_ctrl_pkg::*;
#(
  parameter int N_SRC = DEF_N_SRC,
  parameter int IW = idx_w(N_SRC)
) (
  input  logic [N_SRC-1:0] req,
  input  logic [IW-1:0]    ptr,
  output logic             valid,
  output logic [N_SRC-1:0] grant,
  output logic [IW-1:0]    idx
);
  logic [IW-1:0] k;
  always_comb begin
    valid = 1'b0;
    idx = '0;
    k = '0;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      k = IW'((int'(ptr) + i) % N_SRC);
      if (req[k]) begin
        valid = 1'b1;
        idx = k;
      end
    end
    grant = valid ? N_SRC'(1) << idx : '0;
  end
endmodule

// File: rtl/clk_stall_ctrl.sv
// clk_stall_ctrl: divided processor clock-enable with round-robin stall arbitration and watchdog.
// Optional STALL_PERF_EN adds stall_cycles / stall_count performance counters.
module clk_stall_ctrl
  import clk_stall_ctrl_pkg::*;
#(
  parameter int N_SRC = DEF_N_SRC,
  parameter int DIV_W = DEF_DIV_W,
  parameter int TO_W = DEF_TO_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [DIV_W-1:0] div_ratio,
  input  logic [N_SRC-1:0] stall_req,
  input  logic [N_SRC-1:0] stall_done,
  output logic [N_SRC-1:0] stall_grant,
  output logic             proc_clk_en,
  output logic             stall_active,
`ifdef STALL_PERF_EN
  output logic [31:0]      stall_cycles,
  output logic [15:0]      stall_count,
`endif
  output logic             timeout_err
);
  localparam int IW = idx_w(N_SRC);
  localparam logic [TO_W-1:0] WD_MAX = '1;
  state_t state, state_nxt;
  logic [DIV_W-1:0] div_cnt;
  logic [IW-1:0] rr_ptr, rr_ptr_nxt, gidx, gidx_nxt, arb_idx;
  logic [TO_W-1:0] wd_cnt, wd_cnt_nxt;
  logic [N_SRC-1:0] grant_nxt, arb_grant;
  logic arb_valid, tick, en_nxt, err_nxt, rel;

  // >= so a ratio lowered mid-count wraps at once instead of running to all-ones
  assign tick = div_cnt >= div_ratio;
  assign stall_active = state == STALL;
  assign rel = stall_done[gidx] || wd_cnt == WD_MAX;

  rr_arbiter #(.N_SRC(N_SRC), .IW(IW)) u_arb (
    .req  (stall_req),
    .ptr  (rr_ptr),
    .valid(arb_valid),
    .grant(arb_grant),
    .idx  (arb_idx)
  );

  always_comb begin
    state_nxt = state;
    grant_nxt = stall_grant;
    gidx_nxt = gidx;
    rr_ptr_nxt = rr_ptr;
    wd_cnt_nxt = wd_cnt;
    en_nxt = 1'b0;
    err_nxt = timeout_err;
    case (state)
      IDLE: begin
        en_nxt = tick && !arb_valid;
        if (arb_valid) begin
          state_nxt = STALL;
          grant_nxt = arb_grant;
          gidx_nxt = arb_idx;
          wd_cnt_nxt = '0;
        end
      end
      STALL: begin
        wd_cnt_nxt = wd_cnt + 1'b1;
        if (rel) begin
          state_nxt = RELEASE;
          grant_nxt = '0;
          rr_ptr_nxt = (int'(gidx) == N_SRC - 1) ? '0 : gidx + 1'b1;
          err_nxt = timeout_err || !stall_done[gidx];
        end
      end
      default: begin
        en_nxt = tick;
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      div_cnt <= '0;
      state <= IDLE;
      rr_ptr <= '0;
      gidx <= '0;
      wd_cnt <= '0;
      stall_grant <= '0;
      proc_clk_en <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      div_cnt <= tick ? '0 : div_cnt + 1'b1;
      state <= state_nxt;
      rr_ptr <= rr_ptr_nxt;
      gidx <= gidx_nxt;
      wd_cnt <= wd_cnt_nxt;
      stall_grant <= grant_nxt;
      proc_clk_en <= en_nxt;
      timeout_err <= err_nxt;
    end

`ifdef STALL_PERF_EN
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      stall_cycles <= '0;
      stall_count <= '0;
    end else begin
      stall_cycles <= (stall_active && stall_cycles != 32'hFFFF_FFFF) ? stall_cycles + 1'b1 : stall_cycles;
      stall_count <= (state == IDLE && arb_valid) ? stall_count + 1'b1 : stall_count;
    end
`endif
endmodule

// File: tb/tb_clk_stall_ctrl.sv
// tb_clk_stall_ctrl: directed and randomized stimulus against a behavioural model of the stall controller
module tb_clk_stall_ctrl;
  localparam int N = 3;
  localparam int DW = 4;
  localparam int TW = 4;
  localparam int WD_LIM = (1 << TW) - 1;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [DW-1:0] div_ratio = '0;
  logic [N-1:0] stall_req = '0;
  logic [N-1:0] stall_done = '0;
  logic [N-1:0] stall_grant;
  logic proc_clk_en, stall_active, timeout_err;
`ifdef STALL_PERF_EN
  logic [31:0] stall_cycles;
  logic [15:0] stall_count;
  longint m_cyc;
  int m_cnt;
`endif
  int tests = 0;
  int fails = 0;
  int phase, owner, next_pri, held, m_grant;
  bit busy, rel, m_en, m_err;

  clk_stall_ctrl #(.N_SRC(N), .DIV_W(DW), .TO_W(TW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .div_ratio   (div_ratio),
    .stall_req   (stall_req),
    .stall_done  (stall_done),
    .stall_grant (stall_grant),
    .proc_clk_en (proc_clk_en),
    .stall_active(stall_active),
`ifdef STALL_PERF_EN
    .stall_cycles(stall_cycles),
    .stall_count (stall_count),
`endif
    .timeout_err (timeout_err)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  task automatic check_all();
    check_eq("proc_clk_en", 32'(proc_clk_en), 32'(m_en));
    check_eq("stall_grant", 32'(stall_grant), 32'(m_grant));
    check_eq("stall_active", 32'(stall_active), 32'(busy));
    check_eq("timeout_err", 32'(timeout_err), 32'(m_err));
`ifdef STALL_PERF_EN
    check_eq("stall_cycles", stall_cycles, 32'(m_cyc));
    check_eq("stall_count", 32'(stall_count), 32'(m_cnt));
`endif
  endtask

  task automatic model_reset();
    phase = 0;
    owner = 0;
    next_pri = 0;
    held = 0;
    m_grant = 0;
    busy = 0;
    rel = 0;
    m_en = 0;
    m_err = 0;
`ifdef STALL_PERF_EN
    m_cyc = 0;
    m_cnt = 0;
`endif
  endtask

  // drive inputs for the coming edge and advance the model by that edge
  task automatic apply(input logic [N-1:0] req, input logic [N-1:0] done, input logic [DW-1:0] ratio);
    bit tick, owner_done;
    int r, found;
    stall_req = req;
    stall_done = done;
    div_ratio = ratio;
    r = int'(req);
    tick = phase >= int'(ratio);
    owner_done = ((int'(done) >> owner) & 1) == 1;
`ifdef STALL_PERF_EN
    if (busy && m_cyc < 64'hFFFF_FFFF) m_cyc++;
`endif
    m_en = 0;
    if (busy) begin
      if (owner_done || held == WD_LIM) begin
        if (!owner_done) m_err = 1;
        busy = 0;
        rel = 1;
        m_grant = 0;
        next_pri = (owner + 1) % N;
      end else held++;
    end else if (rel) begin
      rel = 0;
      m_en = tick;
    end else if (r != 0) begin
      found = -1;
      for (int i = 0; i < N; i++)
        if (found < 0 && ((r >> ((next_pri + i) % N)) & 1) == 1) found = (next_pri + i) % N;
      owner = found;
      m_grant = 1 << found;
      busy = 1;
      held = 0;
`ifdef STALL_PERF_EN
      m_cnt = (m_cnt + 1) & 16'hFFFF;
`endif
    end else m_en = tick;
    phase = tick ? 0 : phase + 1;
  endtask

  task automatic step(input logic [N-1:0] req, input logic [N-1:0] done, input logic [DW-1:0] ratio);
    @(negedge clk);
    check_all();
    apply(req, done, ratio);
  endtask

  initial begin
    int pulses;
    int tries;
    logic [N-1:0] req;
    logic [DW-1:0] ratio;
    model_reset();
    #1 check_all();
    @(negedge clk);
    rst_n = 1'b1;
    apply('0, '0, DW'(1));
    pulses = 0;
    repeat (10) begin
      step('0, '0, DW'(1));
      pulses += int'(proc_clk_en);
    end
    check_eq("pulses_div2", 32'(pulses), 32'd5);
    step('0, '0, '0);
    pulses = 0;
    repeat (8) begin
      step('0, '0, '0);
      pulses += int'(proc_clk_en);
    end
    check_eq("pulses_div1", 32'(pulses), 32'd8);
    repeat (30) step('1, '1, DW'(2));
    repeat (40) step(N'(2), '0, '0);
    check_eq("timeout_sticky", 32'(timeout_err), 32'd1);
    req = '0;
    ratio = DW'(3);
    repeat (3000) begin
      if ($urandom_range(49) == 0) ratio = DW'($urandom);
      if ($urandom_range(1) == 1) req = N'($urandom);
      step(req, N'($urandom & $urandom), ratio);
    end
    tries = 0;
    do begin
      step('1, '0, '0);
      tries++;
    end while (!stall_active && tries < 10);
    check_eq("stall_before_rst", 32'(stall_active), 32'd1);
    #2 rst_n = 1'b0;
    #1 check_eq("rst_grant", 32'(stall_grant), 32'd0);
    check_eq("rst_active", 32'(stall_active), 32'd0);
    check_eq("rst_en", 32'(proc_clk_en), 32'd0);
    check_eq("rst_err", 32'(timeout_err), 32'd0);
    @(negedge clk);
    @(negedge clk);
    model_reset();
    rst_n = 1'b1;
    apply('1, '0, '0);
    step('1, '0, '0);
    check_eq("grant_after_rst", 32'(stall_grant), 32'd1);
    repeat (200) step(N'($urandom), N'($urandom), DW'($urandom));
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
